mult_seq: RTL and testbench

- Multi-cycle shift-add multiplier for the MIPS ALU; executes MULT (signed) and MULTU (unsigned) and produces a 2×WIDTH-bit product split into HI/LO.
- Sits directly downstream of the carry-lookahead adder datapath: each iteration issues one WIDTH-bit add (with carry-out) of the multiplicand into the partial-product accumulator.
- Uses a valid/ready handshake on both the operand side and the result side.

---
 rtl/mult_seq.sv | 138 +++++++++++++
 tb/tb_mult_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier for MULT/MULTU, 2*WIDTH-bit product split into hi/lo.
// Latency: res_valid rises WIDTH+1 edges after the accepting edge; accepts no closer than WIDTH+3 cycles.
// Backpressure: start_ready only in IDLE; the result is held in DONE until res_ready.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic               r_neg;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_res_valid;
  logic               r_start_ready;
  logic               r_busy;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_neg;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  // Operand magnitudes (signed mode only) and product sign. The most negative
  // value negates to itself, which is its correct magnitude read as unsigned.
  always_comb begin
    w_abs_a = op_a;
    w_abs_b = op_b;
    if (is_signed && op_a[WIDTH-1]) w_abs_a = ~op_a + 1'b1;
    if (is_signed && op_b[WIDTH-1]) w_abs_b = ~op_b + 1'b1;
    w_neg = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
  end

  // One add per iteration with carry-out; the carry becomes the top accumulator bit after the shift.
  always_comb begin
    w_sum = {1'b0, r_acc};
    if (r_mplier[0]) w_sum = {1'b0, r_acc} + {1'b0, r_mcand};
  end

  // Final product, re-signed with a full-width two's complement when operand signs differ.
  always_comb begin
    w_prod     = {r_acc, r_mplier};
    w_prod_fix = w_prod;
    if (r_neg) w_prod_fix = ~w_prod + 1'b1;
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_acc         <= '0;
      r_neg         <= 1'b0;
      r_count       <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_res_valid   <= 1'b0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_mcand       <= w_abs_a;
            r_mplier      <= w_abs_b;
            r_neg         <= w_neg;
            r_acc         <= '0;
            r_count       <= CW'(WIDTH - 1);
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_CALC;
          end
        end
        S_CALC: begin
          // Fixed iteration count: no early exit on small multipliers.
          r_acc    <= w_sum[WIDTH:1];
          r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
          r_count  <= r_count - 1'b1;
          if (r_count == '0) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi        <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo        <= w_prod_fix[WIDTH-1:0];
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          // A start offered on this edge is not taken: start_ready is still low.
          if (res_ready) begin
            r_res_valid   <= 1'b0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_res_valid   <= 1'b0;
          r_start_ready <= 1'b1;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign res_valid   = r_res_valid;
  assign busy        = r_busy;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mult_seq.sv
// Directed vector bench for mult_seq: product table plus backpressure, operand-change and reset sequences.
module tb_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int busy_low = 0;

  mult_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .is_signed   (is_signed),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    op_a        = a;
    op_b        = b;
    is_signed   = s;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until res_valid; bounded.
  task automatic wait_res(output int edges);
    edges = 0;
    while (!res_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (!busy) busy_low++;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eh, input logic [31:0] el, input string name);
    int edges;
    start_op(a, b, s);
    wait_res(edges);
    check({name, " latency"}, 64'(edges), 64'd33);
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
    consume();
    check({name, " res_valid_drop"}, 64'(res_valid), 64'd0);
    check({name, " start_ready_back"}, 64'(start_ready), 64'd1);
  endtask

  initial begin
    int edges;

    vecs[0]  = '{32'd3,        32'd5,        1'b0, 32'h00000000, 32'h0000000F, "u3x5"};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, "umaxsq"};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001, "sm1xm1"};
    vecs[3]  = '{32'hFFFFFFF9, 32'h00000003, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, "sm7x3"};
    vecs[4]  = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, "sminsq"};
    vecs[5]  = '{32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000, "sminx1"};
    vecs[6]  = '{32'h80000000, 32'h00000002, 1'b0, 32'h00000001, 32'h00000000, "u8x2"};
    vecs[7]  = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000000, "s0xm1"};
    vecs[8]  = '{32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 32'h00000000, "u64k"};
    vecs[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'h3FFFFFFF, 32'h00000001, "smaxsq"};
    vecs[10] = '{32'hFFFFFFFD, 32'hFFFFFFFB, 1'b1, 32'h00000000, 32'h0000000F, "sm3xm5"};
    vecs[11] = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 32'h00000001, 32'hFFFFFFFE, "umaxx2"};

    rst_n       = 1'b1;
    start_valid = 1'b0;
    is_signed   = 1'b0;
    op_a        = '0;
    op_b        = '0;
    res_ready   = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst res_valid", 64'(res_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst start_ready", 64'(start_ready), 64'd1);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].name);
    end
    check("busy during ops", 64'(busy_low), 64'd0);

    // Backpressure: result held 5 cycles, a 9x9 start during the stall is ignored,
    // and the start held through DONE->IDLE is only taken one cycle later.
    start_op(32'd6, 32'd7, 1'b0);
    wait_res(edges);
    check("bp latency", 64'(edges), 64'd33);
    for (int i = 0; i < 5; i++) begin
      check("bp stall res_valid", 64'(res_valid), 64'd1);
      check("bp stall hilo", {hi, lo}, 64'd42);
      check("bp stall start_ready", 64'(start_ready), 64'd0);
      if (i == 1) begin
        op_a        = 32'd9;
        op_b        = 32'd9;
        is_signed   = 1'b0;
        start_valid = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("bp idle res_valid", 64'(res_valid), 64'd0);
    check("bp idle busy", 64'(busy), 64'd0);
    check("bp idle start_ready", 64'(start_ready), 64'd1);
    check("bp hold hilo", {hi, lo}, 64'd42);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    check("bp accept busy", 64'(busy), 64'd1);
    wait_res(edges);
    check("bp9 latency", 64'(edges), 64'd33);
    check("bp9 hilo", {hi, lo}, 64'd81);
    consume();

    // Operands and mode change every cycle after accept; latched values must be used.
    start_op(32'h00001234, 32'h00000100, 1'b0);
    edges = 0;
    while (!res_valid && edges < 200) begin
      op_a      = $urandom;
      op_b      = $urandom;
      is_signed = 1'($urandom_range(0, 1));
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("opchg latency", 64'(edges), 64'd33);
    check("opchg hilo", {hi, lo}, 64'h0000000000123400);
    consume();

    // Reset in the middle of CALC discards the operation and clears the outputs.
    start_op(32'h0000FFFF, 32'h0000FFFF, 1'b0);
    repeat (9) @(negedge clk);
    check("pre-rst busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst hilo", {hi, lo}, 64'd0);
    check("midrst res_valid", 64'(res_valid), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst start_ready", 64'(start_ready), 64'd1);
    do_op(32'd2, 32'd2, 1'b0, 32'd0, 32'd4, "post-rst 2x2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
